// File: rtl/m_demux4_tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : slip_tdm_pkg                                              |
// | Desc     : Shared types and constants for the 4-slot TDM link.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package slip_tdm_pkg;

  typedef enum logic {HUNT, RUN} tdm_state_t;
  typedef logic [1:0] slot_t;

  localparam int NSLOTS = 4;

endpackage : slip_tdm_pkg
`default_nettype wire

// File: rtl/m_demux4_tdm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : m_demux4_tdm_if                                          |
// | Desc      : TDM receive bus: slot strobe/data in, frame/status out.  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface m_demux4_tdm_if #(
  parameter int WIDTH = 8
);
  import slip_tdm_pkg::*;

  logic             EN;
  logic             SYNC;
  logic [WIDTH-1:0] DIN;
  logic             A;
  logic             B;
  logic [WIDTH-1:0] D_0;
  logic [WIDTH-1:0] D_1;
  logic [WIDTH-1:0] D_2;
  logic [WIDTH-1:0] D_3;
  logic             FRAME_VALID;
  logic             LOCKED;
  logic             SYNC_ERR;

  modport master (
    output EN, SYNC, DIN,
    input  A, B, D_0, D_1, D_2, D_3, FRAME_VALID, LOCKED, SYNC_ERR
  );

  modport slave (
    input  EN, SYNC, DIN,
    output A, B, D_0, D_1, D_2, D_3, FRAME_VALID, LOCKED, SYNC_ERR
  );

endinterface : m_demux4_tdm_if
`default_nettype wire

// File: rtl/m_slot_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : m_slot_ctr                                                |
// | Desc     : 2-bit wrapping slot counter with clear and load-to-1.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module m_slot_ctr
  import slip_tdm_pkg::*;
(
  input  wire   clk,
  input  wire   rst_n,
  input  wire   i_clr,
  input  wire   i_load1,
  input  wire   i_inc,
  output slot_t o_slot,
  output logic  o_a,
  output logic  o_b
);

  slot_t r_slot;

  // Clear beats load beats increment; increment wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot <= 2'd0;
    end else if (i_clr) begin
      r_slot <= 2'd0;
    end else if (i_load1) begin
      r_slot <= 2'd1;
    end else if (i_inc) begin
      r_slot <= r_slot + 2'd1;
    end
  end

  assign o_slot = r_slot;
  assign o_a    = r_slot[0];
  assign o_b    = r_slot[1];

endmodule : m_slot_ctr
`default_nettype wire

// File: rtl/m_demux4_tdm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : m_demux4_tdm                                              |
// | Desc     : 4-slot TDM receiver: slot capture, frame publish, resync. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module m_demux4_tdm
  import slip_tdm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RESYNC_MAX = 3
) (
  input  wire            MasterClock,
  input  wire            RESETL,
  m_demux4_tdm_if.slave  bus
);

  localparam logic [0:0] c_HUNT = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;
  localparam int         c_ERR_W = $clog2(RESYNC_MAX + 1);
  localparam logic [c_ERR_W-1:0] c_ERR_LAST = c_ERR_W'(RESYNC_MAX - 1);

  logic [0:0]         r_state;
  logic [c_ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0]   r_shadow [0:NSLOTS-2];
  logic [WIDTH-1:0]   r_d      [0:NSLOTS-1];
  logic               r_frame_valid;
  logic               r_sync_err;

  slot_t w_slot;
  logic  w_run, w_acquire, w_misplaced, w_drop, w_complete, w_advance, w_good_sync;

  assign w_run       = (r_state == c_RUN);
  assign w_acquire   = bus.EN && !w_run && bus.SYNC;
  assign w_misplaced = bus.EN && w_run && bus.SYNC && (w_slot != 2'd0);
  assign w_drop      = w_misplaced && (r_err_cnt == c_ERR_LAST);
  assign w_advance   = bus.EN && w_run && !w_misplaced;
  assign w_complete  = w_advance && (w_slot == 2'd3);
  assign w_good_sync = bus.EN && bus.SYNC && (!w_run || (w_slot == 2'd0));

  m_slot_ctr u_slot_ctr (
    .clk     (MasterClock),
    .rst_n   (RESETL),
    .i_clr   (w_drop),
    .i_load1 (w_acquire || (w_misplaced && !w_drop)),
    .i_inc   (w_advance),
    .o_slot  (w_slot),
    .o_a     (bus.A),
    .o_b     (bus.B)
  );

  always_ff @(posedge MasterClock) begin
    if (!RESETL) begin
      r_state       <= c_HUNT;
      r_err_cnt     <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      for (int i = 0; i < NSLOTS - 1; i++) r_shadow[i] <= '0;
      for (int i = 0; i < NSLOTS; i++)     r_d[i]      <= '0;
    end else begin
      r_frame_valid <= w_complete;
      r_sync_err    <= w_misplaced;

      if (w_acquire) begin
        r_state <= c_RUN;
      end else if (w_drop) begin
        r_state <= c_HUNT;
      end

      if (w_good_sync || w_drop) begin
        r_err_cnt <= '0;
      end else if (w_misplaced) begin
        r_err_cnt <= r_err_cnt + c_ERR_W'(1);
      end

      // A misplaced SYNC restarts the frame, so its word becomes slot 0.
      if (w_acquire || w_misplaced || (w_advance && w_slot == 2'd0)) r_shadow[0] <= bus.DIN;
      if (w_advance && w_slot == 2'd1) r_shadow[1] <= bus.DIN;
      if (w_advance && w_slot == 2'd2) r_shadow[2] <= bus.DIN;

      if (w_complete) begin
        r_d[0] <= r_shadow[0];
        r_d[1] <= r_shadow[1];
        r_d[2] <= r_shadow[2];
        r_d[3] <= bus.DIN;
      end
    end
  end

  assign bus.D_0         = r_d[0];
  assign bus.D_1         = r_d[1];
  assign bus.D_2         = r_d[2];
  assign bus.D_3         = r_d[3];
  assign bus.FRAME_VALID = r_frame_valid;
  assign bus.SYNC_ERR    = r_sync_err;
  assign bus.LOCKED      = w_run;

endmodule : m_demux4_tdm
`default_nettype wire

// File: tb/tb_m_demux4_tdm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_m_demux4_tdm                                           |
// | Desc     : Directed self-checking bench for the TDM receiver.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_m_demux4_tdm;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rstl  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  m_demux4_tdm_if #(.WIDTH(WIDTH)) bus ();

  m_demux4_tdm #(.WIDTH(WIDTH), .RESYNC_MAX(3)) dut (
    .MasterClock (clk),
    .RESETL      (rstl),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic sync, input logic [7:0] din);
    @(negedge clk);
    bus.EN = en; bus.SYNC = sync; bus.DIN = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    chk({tag, ".D_0"}, bus.D_0, d0);
    chk({tag, ".D_1"}, bus.D_1, d1);
    chk({tag, ".D_2"}, bus.D_2, d2);
    chk({tag, ".D_3"}, bus.D_3, d3);
  endtask

  task automatic chk_ab(input string tag, input logic a, input logic b);
    chk({tag, ".A"}, bus.A, a);
    chk({tag, ".B"}, bus.B, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstl = 1'b0; bus.EN = 1'b0; bus.SYNC = 1'b0; bus.DIN = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    rstl = 1'b1;
  endtask

  initial begin
    bus.EN = 1'b0; bus.SYNC = 1'b0; bus.DIN = '0;

    // 1: reset state, then one aligned frame
    @(posedge clk); @(posedge clk); #1;
    chk_frame("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk_ab("rst", 1'b0, 1'b0);
    chk("rst.FV", bus.FRAME_VALID, 1'b0);
    chk("rst.LOCKED", bus.LOCKED, 1'b0);
    chk("rst.SERR", bus.SYNC_ERR, 1'b0);
    @(negedge clk); rstl = 1'b1;
    step(1, 1, 8'h11);
    chk("t1.LOCKED", bus.LOCKED, 1'b1);
    chk_ab("t1.s1", 1'b1, 1'b0);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    chk("t1.FV_early", bus.FRAME_VALID, 1'b0);
    step(1, 0, 8'h44);
    chk("t1.FV", bus.FRAME_VALID, 1'b1);
    chk_frame("t1", 8'h11, 8'h22, 8'h33, 8'h44);
    step(0, 0, 8'h00);
    chk("t1.FV_pulse", bus.FRAME_VALID, 1'b0);

    // 2: HUNT ignores words without SYNC
    do_reset();
    step(1, 0, 8'hAA);
    chk("t2.LOCKED", bus.LOCKED, 1'b0);
    chk_ab("t2", 1'b0, 1'b0);
    chk("t2.D_0", bus.D_0, 8'h00);
    step(0, 0, 8'h00);
    chk("t2.FV", bus.FRAME_VALID, 1'b0);

    // 3: EN gaps between slots 1 and 2
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    chk_ab("t3.s2", 1'b0, 1'b1);
    step(0, 1, 8'hFF);
    chk_ab("t3.gap1", 1'b0, 1'b1);
    chk("t3.gap1.SERR", bus.SYNC_ERR, 1'b0);
    step(0, 0, 8'hEE);
    chk_ab("t3.gap2", 1'b0, 1'b1);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    chk("t3.FV", bus.FRAME_VALID, 1'b1);
    chk_frame("t3", 8'h11, 8'h22, 8'h33, 8'h44);

    // 4: misplaced SYNCs; the third one drops lock
    step(1, 1, 8'h55);
    step(1, 0, 8'h66);
    step(1, 1, 8'h77);
    chk("t4.e1.SERR", bus.SYNC_ERR, 1'b1);
    chk("t4.e1.FV", bus.FRAME_VALID, 1'b0);
    chk_ab("t4.e1", 1'b1, 1'b0);
    chk("t4.e1.LOCKED", bus.LOCKED, 1'b1);
    step(1, 0, 8'h88);
    chk("t4.e1.SERR_pulse", bus.SYNC_ERR, 1'b0);
    step(1, 1, 8'h99);
    chk("t4.e2.SERR", bus.SYNC_ERR, 1'b1);
    chk("t4.e2.LOCKED", bus.LOCKED, 1'b1);
    step(1, 0, 8'h9A);
    step(1, 1, 8'h9B);
    chk("t4.e3.SERR", bus.SYNC_ERR, 1'b1);
    chk("t4.e3.LOCKED", bus.LOCKED, 1'b0);
    chk_ab("t4.e3", 1'b0, 1'b0);
    chk("t4.D_0_held", bus.D_0, 8'h11);

    // 5: reset asserted mid-frame, with a SYNC present, wins
    do_reset();
    step(1, 1, 8'hAA);
    step(1, 0, 8'hBB);
    step(1, 0, 8'hCC);
    step(1, 0, 8'hDD);
    chk_frame("t5.pre", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    @(negedge clk);
    rstl = 1'b0; bus.EN = 1'b1; bus.SYNC = 1'b1; bus.DIN = 8'hEE;
    @(posedge clk); #1;
    chk_frame("t5", 8'h00, 8'h00, 8'h00, 8'h00);
    chk_ab("t5", 1'b0, 1'b0);
    chk("t5.LOCKED", bus.LOCKED, 1'b0);
    chk("t5.FV", bus.FRAME_VALID, 1'b0);
    chk("t5.SERR", bus.SYNC_ERR, 1'b0);
    @(negedge clk); rstl = 1'b1;

    // 6: three back-to-back frames; SYNC only on the first slot 0
    for (int i = 0; i < 12; i++) begin
      int s;
      step(1, (i == 0), 8'(i + 1));
      s = (i + 1) % 4;
      chk_ab($sformatf("t6.%0d", i), s[0], s[1]);
      chk($sformatf("t6.%0d.FV", i), bus.FRAME_VALID, ((i % 4) == 3));
      if ((i % 4) == 3) begin
        chk_frame($sformatf("t6.%0d", i), 8'(i - 2), 8'(i - 1), 8'(i), 8'(i + 1));
      end
    end
    chk("t6.LOCKED", bus.LOCKED, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_m_demux4_tdm
`default_nettype wire
